// File: rtl/sel_data_fifo.sv
// Purpose: buffers Mux32 select-stage words toward the next stage using valid/ready.
// Latency: 1 cycle from push to Data_out/Valid_out (first-word-fall-through, no same-cycle bypass).
// Backpressure: Ready_out drops when full; writes while full are dropped and set sticky Overrun.
module sel_data_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNTW  = 3
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] Data_in,
    input  logic             Valid_in,
    output logic             Ready_out,
    output logic [WIDTH-1:0] Data_out,
    output logic             Valid_out,
    input  logic             Ready_in,
    output logic [CNTW-1:0]  Count_out,
    output logic             Overrun
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             overrun_q, overrun_d;

    logic full, empty, push, pop;

    // Flow-control flags come only from the registered count, so no input reaches an output.
    assign full  = (count_q == CNTW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = Valid_in & ~full;
    assign pop   = Ready_in & ~empty;

    assign Ready_out = ~full;
    assign Valid_out = ~empty;
    assign Count_out = count_q;
    assign Overrun   = overrun_q;
    // Head word is forced to zero while empty so stale storage never leaks out.
    assign Data_out  = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state for pointers, occupancy and the sticky overrun flag.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNTW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNTW'(1);
        end
        // A full FIFO refuses the write even if a pop frees a slot this cycle.
        if (Valid_in && full) begin
            overrun_d = 1'b1;
        end
    end

    // Control state with synchronous active-low reset; reset overrides any transfer.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage is deliberately not cleared by reset; writes are suppressed during reset.
    always_ff @(posedge Clk) begin
        if (Rst_n && push) begin
            mem_q[wr_ptr_q] <= Data_in;
        end
    end

endmodule
